// File: rtl/sram_pkg.sv
// Shared defaults, clear-FSM state type and small helpers for the sram block.
// The clear sweep is compiled in only when SRAM_CLEAR_EN is defined.
package sram_pkg;

  localparam int SRAM_DATA_W = 8;
  localparam int SRAM_ADDR_W = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  // rd is active-low; a read only happens while the chip is selected.
  function automatic logic rd_active(input logic cs, input logic rd);
    return cs & ~rd;
  endfunction

endpackage

// File: rtl/sram_clear_ctrl.sv
// Post-reset clear sweep: writes zero to every word, one per clock, then
// releases the array to the host. Used only in SRAM_CLEAR_EN builds.
module sram_clear_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

  clr_state_e        state_r;
  logic [ADDR_W-1:0] cnt_r;
  logic              busy_r;

  // Sweep FSM: reset always restarts the sweep from word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= CLEAR;
      cnt_r   <= {ADDR_W{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        CLEAR: begin
          if (cnt_r == CNT_LAST) begin
            state_r <= READY;
            cnt_r   <= {ADDR_W{1'b0}};
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        READY: begin
          state_r <= READY;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= CLEAR;
          cnt_r   <= {ADDR_W{1'b0}};
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign clr_we   = (state_r == CLEAR);
  assign clr_addr = cnt_r;

endmodule

// File: rtl/sram.sv
// Single-port synchronous RAM, registered read data, read-before-write.
// Define SRAM_CLEAR_EN to add the post-reset zero sweep and the busy port.
module sram
  import sram_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W,
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DEPTH  = 32'd1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [DATA_W-1:0] dout,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr,
  input  logic              rd,
  input  logic              cs
`ifdef SRAM_CLEAR_EN
  ,
  output logic              busy
`endif
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] dout_r;
  logic              we_s;
  logic              re_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [DATA_W-1:0] wdata_s;

`ifdef SRAM_CLEAR_EN
  logic              clr_we_s;
  logic [ADDR_W-1:0] clr_addr_s;

  sram_clear_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .busy     (busy),
    .clr_we   (clr_we_s),
    .clr_addr (clr_addr_s)
  );

  // While sweeping, the clear port owns the array and host reads are blocked.
  always_comb begin
    we_s    = 1'b0;
    re_s    = 1'b0;
    waddr_s = addr;
    wdata_s = din;
    if (clr_we_s) begin
      we_s    = 1'b1;
      waddr_s = clr_addr_s;
      wdata_s = {DATA_W{1'b0}};
    end else begin
      we_s = cs & wr;
      re_s = rd_active(cs, rd);
    end
  end
`else
  // Host port drives the array directly.
  always_comb begin
    we_s    = cs & wr;
    re_s    = rd_active(cs, rd);
    waddr_s = addr;
    wdata_s = din;
  end
`endif

  // Array: a write coinciding with reset is dropped, contents otherwise kept.
  always_ff @(posedge clk) begin
    if (rst_n && we_s) begin
      mem_r[waddr_s] <= wdata_s;
    end
  end

  // Read register samples the old word, giving read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r <= {DATA_W{1'b0}};
    end else if (re_s) begin
      dout_r <= mem_r[addr];
    end
  end

  assign dout = dout_r;

endmodule

// File: tb/tb_sram.sv
// Self-checking bench for sram: directed scenarios plus random traffic
// compared against an array model of the memory and the read register.
module tb_sram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] dout;
  logic [7:0] din;
  logic [7:0] addr;
  logic       wr;
  logic       rd;
  logic       cs;
`ifdef SRAM_CLEAR_EN
  logic       busy;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] model [256];
  logic [7:0] exp_dout;

  sram dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dout  (dout),
    .din   (din),
    .addr  (addr),
    .wr    (wr),
    .rd    (rd),
    .cs    (cs)
`ifdef SRAM_CLEAR_EN
    ,
    .busy  (busy)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of host traffic; the model applies read-before-write.
  task automatic op(input logic c, input logic w, input logic r,
                    input logic [7:0] a, input logic [7:0] d);
    cs = c; wr = w; rd = r; addr = a; din = d;
    @(posedge clk);
    #1;
    if (c && !r) exp_dout = model[a];
    if (c && w) model[a] = d;
    cs = 1'b0; wr = 1'b0; rd = 1'b1;
  endtask

  task automatic write(input logic [7:0] a, input logic [7:0] d);
    op(1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a);
    op(1'b1, 1'b0, 1'b0, a, 8'h00);
    check(tag, dout, exp_dout);
  endtask

  // After reset: in clear builds count busy cycles and zero the model.
  task automatic wait_ready();
`ifdef SRAM_CLEAR_EN
    int n = 0;
    while (busy === 1'b1 && n < 1000) begin
      cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = 8'($urandom); din = 8'hFF;
      @(posedge clk);
      #1;
      n++;
      if (busy === 1'b1) check("clear_dout", dout, 32'h0);
    end
    cs = 1'b0; wr = 1'b0; rd = 1'b1;
    check("busy_cycles", n, 32'd256);
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
`else
    @(negedge clk);
`endif
  endtask

  initial begin
    logic [7:0] t2_addr [5];
    logic [7:0] t2_data [5];
    t2_addr = '{8'h02, 8'h04, 8'h05, 8'h09, 8'h2F};
    t2_data = '{8'h04, 8'h10, 8'h21, 8'h81, 8'hF5};

    exp_dout = 8'h00;
    rst_n = 1'b0; cs = 1'b0; wr = 1'b0; rd = 1'b1; addr = 8'h00; din = 8'h00;
    #1;
    check("reset_dout", dout, 32'h0);
`ifdef SRAM_CLEAR_EN
    check("reset_busy", busy, 32'h1);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ready();

    // Fill the whole array so every later read has a known expectation.
    for (int i = 0; i < 256; i++) write(8'(i), 8'($urandom));

    // Test 1
    write(8'h01, 8'h01);
    read_chk("t1_read", 8'h01);
    check("t1_const", dout, 32'h01);

    // Test 2
    for (int i = 0; i < 5; i++) write(t2_addr[i], t2_data[i]);
    for (int i = 0; i < 5; i++) begin
      read_chk("t2_read", t2_addr[i]);
      check("t2_const", dout, t2_data[i]);
    end
    read_chk("t2_other", 8'h03);
    read_chk("t2_other", 8'h2E);

    // Test 3: deselected write and read must not disturb anything
    write(8'h01, 8'h61);
    read_chk("t3_read", 8'h01);
    check("t3_const", dout, 32'h61);
    op(1'b0, 1'b1, 1'b0, 8'h01, 8'hFF);
    check("t3_cs0_hold", dout, 32'h61);
    read_chk("t3_reread", 8'h01);
    check("t3_reread_const", dout, 32'h61);

    // Test 4: same-cycle write and read returns the old contents
    write(8'h29, 8'hA5);
    op(1'b1, 1'b1, 1'b0, 8'h29, 8'h5A);
    check("t4_rbw", dout, 32'hA5);
    read_chk("t4_new", 8'h29);
    check("t4_new_const", dout, 32'h5A);

    // Test 6: idle cycles hold dout
    write(8'h0F, 8'h0F);
    read_chk("t6_read", 8'h0F);
    for (int i = 0; i < 3; i++) begin
      op(1'b1, 1'b0, 1'b1, 8'(i), 8'h00);
      check("t6_hold", dout, 32'h0F);
    end

    // Test 5: reset with a write in flight
    write(8'h65, 8'h55);
    read_chk("t5_pre", 8'h0F);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = 8'h65; din = 8'h99;
    #2 rst_n = 1'b0;
    #1 check("t5_async_dout", dout, 32'h0);
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
    rst_n = 1'b1;
    exp_dout = 8'h00;
    wait_ready();
    read_chk("t5_after", 8'h65);
`ifdef SRAM_CLEAR_EN
    check("t5_after_const", dout, 32'h00);
`else
    check("t5_after_const", dout, 32'h55);
`endif

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      op(($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom),
         8'($urandom), 8'($urandom));
      check("rand_dout", dout, exp_dout);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
